spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter IDLE_BYTE, 8'hFF, byte shifted out on MISO when no TX byte is buffered.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer depth for sclk/mosi/_cs (legal 2..3).
REQ-003 clk7  input  1  7MHz system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 sclk  input  1  SPI clock from external initiator, asynchronous to clk7, CPOL=0/CPHA=0.
REQ-006 mosi  input  1  SPI data in, MSB first.
REQ-007 _cs  input  1  SPI chip select, active low, asynchronous.
REQ-008 miso  output  1  SPI data out, MSB first.
REQ-009 miso_oe  output  1  MISO drive enable, high only while selected.
REQ-010 selected  output  1  synchronized select state.
REQ-011 rx_data  output  8  last completed received byte.
REQ-012 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-013 rx_ack  input  1  consumer pulse, clears rx_valid.
REQ-014 tx_data  input  8  next byte to transmit.
REQ-015 tx_load  input  1  writes tx_data into the TX buffer when tx_ready=1.
REQ-016 tx_ready  output  1  TX buffer empty.
REQ-017 overrun  output  1  sticky: RX byte completed while rx_valid=1.
REQ-018 underrun  output  1  sticky: IDLE_BYTE substituted for an empty TX buffer.
REQ-019 status_clr  input  1  clears overrun and underrun.

Function
REQ-020 sclk, mosi, _cs SHALL each pass SYNC_STAGES flops; edges are detected on the synchronized sclk; the initiator SHALL hold sclk high and low each >=4 clk7 periods.
REQ-021 FSM states IDLE and ACTIVE; IDLE->ACTIVE on synchronized _cs high->low; ACTIVE->IDLE on synchronized _cs low->high; selected=1 and miso_oe=1 exactly in ACTIVE.
REQ-022 On IDLE->ACTIVE: bit counter=0; TX shift register loaded from TX buffer (tx_ready->1) or, if empty, with IDLE_BYTE and underrun set.
REQ-023 miso SHALL equal TX shift bit 7 while ACTIVE, and 1 while IDLE.
REQ-024 Synchronized sclk rising edge: mosi sample shifted into RX shift register LSB, bit counter +1 (mod 8).
REQ-025 On the 8th rising edge the next clk7 SHALL load rx_data with the 8 bits (first bit = bit 7) and set rx_valid.
REQ-026 Byte completion with rx_valid=1 SHALL overwrite rx_data and set overrun; completion in the same cycle as rx_ack leaves rx_valid=1 with no overrun.
REQ-027 rx_ack with no completion SHALL clear rx_valid the next cycle; rx_ack with rx_valid=0 is ignored.
REQ-028 Synchronized sclk falling edge with bit counter!=0: TX shift register shifts left by one.
REQ-029 Falling edge with bit counter=0 (byte boundary): TX shift register reloads per REQ-022 rules, including underrun.
REQ-030 tx_load with tx_ready=1 SHALL store tx_data and clear tx_ready next cycle; tx_load with tx_ready=0 is ignored, buffer unchanged, including the cycle the buffer is consumed.
REQ-031 _cs deassert mid-byte: partial RX bits discarded, no rx_valid, bit counter=0, TX shift contents discarded, TX buffer untouched.
REQ-032 status_clr clears both flags next cycle; a set event in the same cycle wins.
REQ-033 Latency sclk pin edge to internal action SHALL be SYNC_STAGES+1 clk7 cycles.

Reset
REQ-034 On reset: state IDLE, bit counter 0, miso=1, miso_oe=0, selected=0, rx_data=8'h00, rx_valid=0, tx_ready=1, overrun=0, underrun=0, shift registers 0.
REQ-035 reset mid-transfer SHALL abort like REQ-031 and also empty the TX buffer; the target re-arms only on a new _cs falling edge.

Verification
REQ-036 tx_load 8'hA5, _cs low, initiator sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid=1, underrun=0.
REQ-037 No tx_load, _cs low, two bytes 8'h01,8'h02 without rx_ack -> MISO 8'hFF twice, underrun=1, rx_data=8'h02, overrun=1.
REQ-038 _cs high after 5 sclk cycles, then new frame of 8'h81 -> no rx_valid after abort, then rx_data=8'h81, bit alignment correct.
REQ-039 tx_load 8'h11 then second tx_load 8'h22 while tx_ready=0 -> MISO sends 8'h11; 8'h22 lost; tx_ready=1 after CS fall.
REQ-040 rx_ack coincident with 8th-bit completion, and status_clr coincident with underrun set -> rx_valid stays 1, overrun=0, underrun=1.
REQ-041 reset asserted mid-byte -> all outputs at REQ-034 values next cycle; next frame of 8'h5A received correctly.

Source files
------------

// File: rtl/spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_target
//  Purpose  : SPI mode-0 target with oversampled sclk, one-byte TX buffer,
//             RX holding register and sticky overrun/underrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
   parameter logic [7:0] IDLE_BYTE   = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk7,
   input  logic       reset,
   input  logic       sclk,
   input  logic       mosi,
   input  logic       _cs,
   output logic       miso,
   output logic       miso_oe,
   output logic       selected,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic       overrun,
   output logic       underrun,
   input  logic       status_clr
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;

   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_rx_shift;
   logic [7:0] r_tx_shift;
   logic [7:0] r_tx_buf;

   logic       w_sclk_s;
   logic       w_mosi_s;
   logic       w_cs_s;
   logic       w_sclk_rise;
   logic       w_sclk_fall;
   logic       w_cs_fall;
   logic       w_cs_rise;
   logic [7:0] w_rx_byte;
   logic [7:0] w_load_shift;

   // Chains reset low so a _cs already held low after reset is not seen as a fall.
   always_ff @(posedge clk7) begin
      if (reset) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], _cs};
         r_sclk_prev <= w_sclk_s;
         r_cs_prev   <= w_cs_s;
      end
   end

   assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_rise  = w_sclk_s & ~r_sclk_prev;
   assign w_sclk_fall  = ~w_sclk_s & r_sclk_prev;
   assign w_cs_fall    = ~w_cs_s & r_cs_prev;
   assign w_cs_rise    = w_cs_s & ~r_cs_prev;
   assign w_rx_byte    = {r_rx_shift, w_mosi_s};
   assign w_load_shift = tx_ready ? IDLE_BYTE : r_tx_buf;

   always_ff @(posedge clk7) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_rx_shift <= 7'd0;
         r_tx_shift <= 8'd0;
         r_tx_buf   <= 8'd0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         tx_ready   <= 1'b1;
         overrun    <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         // Clears come first so any set event later in this block wins.
         if (status_clr) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
         end
         if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
         end
         if (tx_load && tx_ready) begin
            r_tx_buf <= tx_data;
            tx_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state    <= ST_ACTIVE;
                  r_bit_cnt  <= 3'd0;
                  r_tx_shift <= w_load_shift;
                  if (tx_ready) underrun <= 1'b1;
                  else          tx_ready <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_state    <= ST_IDLE;
                  r_bit_cnt  <= 3'd0;
                  r_rx_shift <= 7'd0;
                  r_tx_shift <= 8'd0;
               end else if (w_sclk_rise) begin
                  r_rx_shift <= w_rx_byte[6:0];
                  r_bit_cnt  <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     rx_data  <= w_rx_byte;
                     rx_valid <= 1'b1;
                     if (rx_valid && !rx_ack) overrun <= 1'b1;
                  end
               end else if (w_sclk_fall) begin
                  if (r_bit_cnt != 3'd0) begin
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  end else begin
                     r_tx_shift <= w_load_shift;
                     if (tx_ready) underrun <= 1'b1;
                     else          tx_ready <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign selected = (r_state == ST_ACTIVE);
   assign miso_oe  = (r_state == ST_ACTIVE);
   assign miso     = (r_state == ST_ACTIVE) ? r_tx_shift[7] : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_target
//  Purpose  : Directed SPI initiator with queued expectations for spi_target.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

   localparam int HALF = 6;

   logic       clk7 = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       tx_load = 1'b0;
   logic       status_clr = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic       selected;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;
   logic       overrun;
   logic       underrun;

   spi_target #(
      .IDLE_BYTE   (8'hFF),
      .SYNC_STAGES (2)
   ) dut (
      .clk7       (clk7),
      .reset      (reset),
      .sclk       (sclk),
      .mosi       (mosi),
      ._cs        (cs_n),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .selected   (selected),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .tx_ready   (tx_ready),
      .overrun    (overrun),
      .underrun   (underrun),
      .status_clr (status_clr)
   );

   always #5 clk7 = ~clk7;

   typedef struct packed {
      logic [7:0] data;
      logic       ov;
      logic       ur;
   } rx_exp_t;

   rx_exp_t    rx_q[$];
   logic [7:0] miso_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk7);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_tx_load(input logic [7:0] b);
      tx_data = b;
      tx_load = 1'b1;
      wait_neg(1);
      tx_load = 1'b0;
   endtask

   // With clr set, status_clr lands on the same clk7 edge that acts on the _cs fall.
   task automatic cs_fall(input bit clr);
      cs_n = 1'b0;
      if (clr) begin
         wait_neg(2);
         status_clr = 1'b1;
         wait_neg(1);
         status_clr = 1'b0;
         wait_neg(HALF - 3);
      end else begin
         wait_neg(HALF);
      end
   endtask

   task automatic cs_rise();
      wait_neg(HALF);
      cs_n = 1'b1;
      wait_neg(2 * HALF);
   endtask

   task automatic spi_bits(input logic [7:0] b, input int nbits, input bit ack_last);
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         wait_neg(HALF);
         sclk = 1'b1;
         if (ack_last && i == 7) begin
            wait_neg(2);
            rx_ack = 1'b1;
            wait_neg(1);
            rx_ack = 1'b0;
            wait_neg(HALF - 3);
         end else begin
            wait_neg(HALF);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] mosi_b, input logic [7:0] exp_miso,
                       input logic [7:0] exp_rx, input logic exp_ov,
                       input logic exp_ur, input bit ack_last);
      miso_q.push_back(exp_miso);
      rx_q.push_back({exp_rx, exp_ov, exp_ur});
      spi_bits(mosi_b, 8, ack_last);
   endtask

   task automatic ack_and_clear();
      rx_ack = 1'b1;
      wait_neg(1);
      rx_ack = 1'b0;
      status_clr = 1'b1;
      wait_neg(1);
      status_clr = 1'b0;
      wait_neg(1);
      chk1("ack_rx_valid", rx_valid, 1'b0);
      chk1("clr_overrun", overrun, 1'b0);
      chk1("clr_underrun", underrun, 1'b0);
   endtask

   // Initiator-side capture of MISO, sampled on the sclk rising pin edge.
   int         mbits = 0;
   logic [7:0] mbyte = 8'd0;
   logic [7:0] mexp;
   always @(posedge sclk or posedge cs_n) begin
      if (cs_n) begin
         mbits = 0;
      end else begin
         mbyte = {mbyte[6:0], miso};
         mbits++;
         if (mbits == 8) begin
            mbits = 0;
            n_checks++;
            if (miso_q.size() == 0) begin
               n_fail++;
               $display("FAIL miso_byte: got %02h with nothing expected", mbyte);
            end else begin
               mexp = miso_q.pop_front();
               if (mbyte !== mexp) begin
                  n_fail++;
                  $display("FAIL miso_byte: got %02h expected %02h", mbyte, mexp);
               end
            end
         end
      end
   end

   // A new received byte shows up as rx_valid rising or rx_data changing while valid.
   logic       prev_v = 1'b0;
   logic [7:0] prev_d = 8'd0;
   rx_exp_t    rexp;
   always @(negedge clk7) begin
      if (!reset && rx_valid && (!prev_v || rx_data !== prev_d)) begin
         n_checks++;
         if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_byte: got %02h with nothing expected", rx_data);
         end else begin
            rexp = rx_q.pop_front();
            if (rx_data !== rexp.data || overrun !== rexp.ov || underrun !== rexp.ur) begin
               n_fail++;
               $display("FAIL rx_byte: got data=%02h ov=%b ur=%b expected data=%02h ov=%b ur=%b",
                        rx_data, overrun, underrun, rexp.data, rexp.ov, rexp.ur);
            end
         end
      end
      prev_v = rx_valid;
      prev_d = rx_data;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_neg(4);
      reset = 1'b0;
      wait_neg(4);
      chk1("rst_miso", miso, 1'b1);
      chk1("rst_miso_oe", miso_oe, 1'b0);
      chk1("rst_selected", selected, 1'b0);
      chk8("rst_rx_data", rx_data, 8'h00);
      chk1("rst_rx_valid", rx_valid, 1'b0);
      chk1("rst_tx_ready", tx_ready, 1'b1);
      chk1("rst_overrun", overrun, 1'b0);
      chk1("rst_underrun", underrun, 1'b0);

      // Buffered A5 out, 3C in
      do_tx_load(8'hA5);
      chk1("t1_tx_ready_full", tx_ready, 1'b0);
      cs_fall(1'b0);
      chk1("t1_selected", selected, 1'b1);
      chk1("t1_miso_oe", miso_oe, 1'b1);
      chk1("t1_tx_ready_consumed", tx_ready, 1'b1);
      chk1("t1_underrun", underrun, 1'b0);
      send(8'h3C, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
      cs_rise();
      chk1("t1_deselected", selected, 1'b0);
      chk1("t1_idle_miso", miso, 1'b1);
      chk1("t1_idle_miso_oe", miso_oe, 1'b0);
      ack_and_clear();

      // Two bytes with empty buffer and no ack
      cs_fall(1'b0);
      send(8'h01, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
      send(8'h02, 8'hFF, 8'h02, 1'b1, 1'b1, 1'b0);
      cs_rise();
      chk1("t2_overrun", overrun, 1'b1);
      chk1("t2_underrun", underrun, 1'b1);
      ack_and_clear();

      // Abort after 5 bits, buffer loaded mid-frame survives
      cs_fall(1'b0);
      spi_bits(8'hF0, 5, 1'b0);
      do_tx_load(8'h5C);
      cs_rise();
      chk1("t3_abort_rx_valid", rx_valid, 1'b0);
      chk1("t3_abort_tx_ready", tx_ready, 1'b0);
      chk1("t3_abort_selected", selected, 1'b0);
      status_clr = 1'b1;
      wait_neg(1);
      status_clr = 1'b0;
      cs_fall(1'b0);
      chk1("t3_tx_ready_consumed", tx_ready, 1'b1);
      send(8'h81, 8'h5C, 8'h81, 1'b0, 1'b0, 1'b0);
      cs_rise();
      ack_and_clear();

      // Second tx_load while full is dropped
      do_tx_load(8'h11);
      do_tx_load(8'h22);
      chk1("t4_tx_ready_full", tx_ready, 1'b0);
      cs_fall(1'b0);
      chk1("t4_tx_ready_consumed", tx_ready, 1'b1);
      send(8'h7E, 8'h11, 8'h7E, 1'b0, 1'b0, 1'b0);
      cs_rise();
      ack_and_clear();

      // status_clr against underrun set, rx_ack against completion
      cs_fall(1'b1);
      chk1("t5_underrun_wins", underrun, 1'b1);
      chk1("t5_overrun", overrun, 1'b0);
      send(8'h66, 8'hFF, 8'h66, 1'b0, 1'b1, 1'b0);
      send(8'h99, 8'hFF, 8'h99, 1'b0, 1'b1, 1'b1);
      chk1("t5_rx_valid_kept", rx_valid, 1'b1);
      chk1("t5_no_overrun", overrun, 1'b0);
      chk8("t5_rx_data", rx_data, 8'h99);
      cs_rise();
      ack_and_clear();

      // Reset mid-byte with a pending TX byte
      do_tx_load(8'h3A);
      cs_fall(1'b0);
      do_tx_load(8'h77);
      chk1("t6_tx_ready_full", tx_ready, 1'b0);
      spi_bits(8'hC3, 4, 1'b0);
      reset = 1'b1;
      wait_neg(1);
      reset = 1'b0;
      chk1("t6_miso", miso, 1'b1);
      chk1("t6_miso_oe", miso_oe, 1'b0);
      chk1("t6_selected", selected, 1'b0);
      chk8("t6_rx_data", rx_data, 8'h00);
      chk1("t6_rx_valid", rx_valid, 1'b0);
      chk1("t6_tx_ready", tx_ready, 1'b1);
      chk1("t6_overrun", overrun, 1'b0);
      chk1("t6_underrun", underrun, 1'b0);
      wait_neg(10);
      chk1("t6_no_rearm", selected, 1'b0);
      cs_rise();
      cs_fall(1'b0);
      chk1("t6_reselected", selected, 1'b1);
      send(8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1, 1'b0);
      cs_rise();

      wait_neg(20);
      chk_int("miso_queue_drained", miso_q.size(), 0);
      chk_int("rx_queue_drained", rx_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
